// File: rtl/alu_op_issuer_pkg.sv
// Shared opcode codes, FSM state encoding and helpers for the ALU operation issuer.
package alu_op_issuer_pkg;

  localparam int OP_AND   = 0;
  localparam int OP_OR    = 1;
  localparam int OP_XOR   = 2;
  localparam int OP_NOT   = 3;
  localparam int OP_SUM   = 4;
  localparam int OP_SUB   = 5;
  localparam int OP_ASL   = 6;
  localparam int OP_COMP2 = 7;
  localparam int OP_LAST  = OP_COMP2;

  // Settle counter width: SETTLE_CYCLES ranges over 0..15.
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Opcodes above OP_LAST have no ALU meaning and are answered with an error.
  function automatic logic op_is_legal(input int unsigned op);
    return (op <= OP_LAST);
  endfunction

endpackage

// File: rtl/alu_op_issuer_if.sv
// Command, ALU and result ports of the issuer grouped into one bundle.
interface alu_op_issuer_if #(
  parameter int N = 3
);
  logic       cmd_valid;
  logic       cmd_ready;
  logic [N:0] cmd_op;
  logic [N:0] cmd_a;
  logic [N:0] cmd_b;
  logic       cmd_chain;

  logic [N:0] alu_operation;
  logic [N:0] alu_input1;
  logic [N:0] alu_input2;
  logic [N:0] alu_output1;

  logic       res_valid;
  logic       res_ready;
  logic [N:0] res_data;
  logic       res_err;

  // Issuer side.
  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_chain, alu_output1, res_ready,
    output cmd_ready, alu_operation, alu_input1, alu_input2, res_valid, res_data, res_err
  );

  // Command producer / ALU / result consumer side.
  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_chain, alu_output1, res_ready,
    input  cmd_ready, alu_operation, alu_input1, alu_input2, res_valid, res_data, res_err
  );
endinterface

// File: rtl/alu_issue_timer.sv
// Settle-cycle down-counter: load a start value, decrement on request, flag zero.
module alu_issue_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Load takes priority; decrement saturates at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/alu_op_issuer.sv
// Issues one command to a combinational ALU, waits for it to settle, and returns
// the captured result; keeps an accumulator for chained commands.
module alu_op_issuer
  import alu_op_issuer_pkg::*;
#(
  parameter int N             = 3,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  alu_op_issuer_if.slave   bus,
  output logic             busy,
  output logic [7:0]       res_count
);

  state_t     state_q, state_d;
  logic [N:0] op_q, op_d;
  logic [N:0] in1_q, in1_d;
  logic [N:0] in2_q, in2_d;
  logic [N:0] acc_q, acc_d;
  logic [N:0] res_data_q, res_data_d;
  logic       res_err_q, res_err_d;
  logic       res_valid_q, res_valid_d;
  logic       cmd_ready_q, cmd_ready_d;
  logic       busy_q, busy_d;
  logic [7:0] res_count_q, res_count_d;

  logic       timer_load;
  logic       timer_dec;
  logic       timer_zero;

  alu_issue_timer #(
    .W(CNT_W)
  ) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (timer_load),
    .load_val(CNT_W'(SETTLE_CYCLES)),
    .dec     (timer_dec),
    .zero    (timer_zero)
  );

  // Next-state logic: handshake outputs are computed one cycle ahead so they leave flops.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    in1_d       = in1_q;
    in2_d       = in2_q;
    acc_d       = acc_q;
    res_data_d  = res_data_q;
    res_err_d   = res_err_q;
    res_valid_d = res_valid_q;
    cmd_ready_d = cmd_ready_q;
    busy_d      = busy_q;
    res_count_d = res_count_q;
    timer_load  = 1'b0;
    timer_dec   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          cmd_ready_d = 1'b0;
          busy_d      = 1'b1;
          if (op_is_legal(32'(bus.cmd_op))) begin
            // Only legal commands ever reach the ALU ports.
            op_d       = bus.cmd_op;
            in1_d      = bus.cmd_chain ? acc_q : bus.cmd_a;
            in2_d      = bus.cmd_b;
            timer_load = 1'b1;
            state_d    = ST_WAIT;
          end else begin
            res_data_d  = '0;
            res_err_d   = 1'b1;
            res_valid_d = 1'b1;
            state_d     = ST_DONE;
          end
        end
      end
      ST_WAIT: begin
        if (timer_zero) begin
          res_data_d  = bus.alu_output1;
          acc_d       = bus.alu_output1;
          res_err_d   = 1'b0;
          res_valid_d = 1'b1;
          state_d     = ST_DONE;
        end else begin
          timer_dec = 1'b1;
        end
      end
      ST_DONE: begin
        if (bus.res_ready) begin
          res_count_d = res_count_q + 8'd1;
          res_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          busy_d      = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        res_valid_d = 1'b0;
        cmd_ready_d = 1'b1;
        busy_d      = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  // FSM, operand latches, accumulator and result registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      op_q        <= '0;
      in1_q       <= '0;
      in2_q       <= '0;
      acc_q       <= '0;
      res_data_q  <= '0;
      res_err_q   <= 1'b0;
      res_valid_q <= 1'b0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      res_count_q <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      in1_q       <= in1_d;
      in2_q       <= in2_d;
      acc_q       <= acc_d;
      res_data_q  <= res_data_d;
      res_err_q   <= res_err_d;
      res_valid_q <= res_valid_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      res_count_q <= res_count_d;
    end
  end

  assign bus.cmd_ready     = cmd_ready_q;
  assign bus.alu_operation = op_q;
  assign bus.alu_input1    = in1_q;
  assign bus.alu_input2    = in2_q;
  assign bus.res_valid     = res_valid_q;
  assign bus.res_data      = res_data_q;
  assign bus.res_err       = res_err_q;
  assign busy              = busy_q;
  assign res_count         = res_count_q;

endmodule
